// File: rtl/mfp_adc_max10_stub_if.sv
// ADC command/response bundle between a sequencer client and the ADC responder.
// master: drives commands and receives responses; slave: the ADC side.
// The response path has no ready signal; beats are single-cycle pulses.
interface mfp_adc_max10_stub_if;
   logic        ADC_C_Valid;
   logic [4:0]  ADC_C_Channel;
   logic        ADC_C_SOP;
   logic        ADC_C_EOP;
   logic        ADC_C_Ready;
   logic        ADC_R_Valid;
   logic [4:0]  ADC_R_Channel;
   logic [11:0] ADC_R_Data;
   logic        ADC_R_SOP;
   logic        ADC_R_EOP;

   modport master (
      output ADC_C_Valid, ADC_C_Channel, ADC_C_SOP, ADC_C_EOP,
      input  ADC_C_Ready,
      input  ADC_R_Valid, ADC_R_Channel, ADC_R_Data, ADC_R_SOP, ADC_R_EOP
   );

   modport slave (
      input  ADC_C_Valid, ADC_C_Channel, ADC_C_SOP, ADC_C_EOP,
      output ADC_C_Ready,
      output ADC_R_Valid, ADC_R_Channel, ADC_R_Data, ADC_R_SOP, ADC_R_EOP
   );
endinterface

// File: rtl/mfp_adc_max10_stub.sv
// Purpose: stand-in for the MAX10 modular ADC sequencer; echoes each command with pattern data.
// Latency: accept in cycle 0 (idle, empty) -> response pulse in cycle CONV_CYCLES+2.
// Backpressure: ADC_C_Ready = !full of the command FIFO; responses cannot be stalled.
// Optional macro ADC_STUB_EXT_DATA_EN adds ext_data/ext_sel to override the sample data.
module mfp_adc_max10_stub #(
   parameter int CONV_CYCLES = 16,   // 1..255
   parameter int FIFO_DEPTH  = 4     // power of 2, 2..16
) (
   input  logic                CLK,
   input  logic                RESETn,
`ifdef ADC_STUB_EXT_DATA_EN
   input  logic [11:0]         ext_data,
   input  logic                ext_sel,
`endif
   mfp_adc_max10_stub_if.slave adc
);
   localparam int         AW       = $clog2(FIFO_DEPTH);
   localparam logic [AW:0] DEPTH_C  = (AW+1)'(FIFO_DEPTH);
   localparam logic [7:0]  CNT_LOAD = 8'(CONV_CYCLES - 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_CONV = 2'd1;
   localparam logic [1:0] S_RESP = 2'd2;

   // Command FIFO: entry = {channel, sop, eop}
   logic [6:0]    r_mem [FIFO_DEPTH];
   logic [AW-1:0] r_wp;
   logic [AW-1:0] r_rp;
   logic [AW:0]   r_cnt;

   // Sequencer state and working register
   logic [1:0]  r_state;
   logic [7:0]  r_tmr;
   logic [4:0]  r_ch;
   logic        r_sop;
   logic        r_eop;
   logic [6:0]  r_seq;
   logic        r_rdy_en;

   logic        w_full;
   logic        w_empty;
   logic        w_push;
   logic        w_pop;
   logic        w_resp;
   logic [11:0] w_pat;
   logic [11:0] w_data;

   assign w_full  = (r_cnt == DEPTH_C);
   assign w_empty = (r_cnt == '0);
   // Ready is held low through reset and rises on the first edge after release.
   assign adc.ADC_C_Ready = r_rdy_en & ~w_full;
   assign w_push  = adc.ADC_C_Valid & adc.ADC_C_Ready;
   // The sequencer only takes a new command from IDLE.
   assign w_pop   = (r_state == S_IDLE) & ~w_empty;
   assign w_resp  = (r_state == S_RESP);

   // FIFO storage write; contents need no reset since the count gates reads.
   always_ff @(posedge CLK) begin
      if (w_push) begin
         r_mem[r_wp] <= {adc.ADC_C_Channel, adc.ADC_C_SOP, adc.ADC_C_EOP};
      end
   end

   // FIFO pointers and occupancy; simultaneous push and pop keep the count.
   always_ff @(posedge CLK or negedge RESETn) begin
      if (!RESETn) begin
         r_wp     <= '0;
         r_rp     <= '0;
         r_cnt    <= '0;
         r_rdy_en <= 1'b0;
      end else begin
         r_rdy_en <= 1'b1;
         if (w_push) r_wp <= r_wp + 1'b1;
         if (w_pop)  r_rp <= r_rp + 1'b1;
         if (w_push && !w_pop) begin
            r_cnt <= r_cnt + 1'b1;
         end else if (!w_push && w_pop) begin
            r_cnt <= r_cnt - 1'b1;
         end
      end
   end

   // Conversion sequencer: IDLE pops, CONV counts down, RESP emits one beat.
   always_ff @(posedge CLK or negedge RESETn) begin
      if (!RESETn) begin
         r_state <= S_IDLE;
         r_tmr   <= '0;
         r_ch    <= '0;
         r_sop   <= 1'b0;
         r_eop   <= 1'b0;
         r_seq   <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (!w_empty) begin
                  {r_ch, r_sop, r_eop} <= r_mem[r_rp];
                  r_tmr   <= CNT_LOAD;
                  r_state <= S_CONV;
               end
            end
            S_CONV: begin
               if (r_tmr == 8'd0) begin
                  r_state <= S_RESP;
               end else begin
                  r_tmr <= r_tmr - 1'b1;
               end
            end
            S_RESP: begin
               // seq advances for every response, including out-of-range channels
               r_seq   <= r_seq + 1'b1;
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // Sample data: channel/sequence pattern for real channels, all-ones otherwise.
   always_comb begin
      w_pat = (r_ch <= 5'd17) ? {r_ch, r_seq} : 12'hFFF;
`ifdef ADC_STUB_EXT_DATA_EN
      w_data = ext_sel ? ext_data : w_pat;
`else
      w_data = w_pat;
`endif
   end

   // Response fields are forced to zero outside the single RESP cycle.
   assign adc.ADC_R_Valid   = w_resp;
   assign adc.ADC_R_Channel = w_resp ? r_ch   : 5'd0;
   assign adc.ADC_R_Data    = w_resp ? w_data : 12'd0;
   assign adc.ADC_R_SOP     = w_resp & r_sop;
   assign adc.ADC_R_EOP     = w_resp & r_eop;

endmodule
